peripheral_noc_traffic_gen: RTL
===============================

Name: peripheral_noc_traffic_gen

Overview:
- Per-node synthetic packet source driving one local injection channel (flit/last/valid/ready) of the mesh NoC.
- Emits fixed-length packets to pseudo-random destinations, with a programmable inter-packet gap and packet count.
- Used by NoC benches and bring-up.
- One instance per node/channel; the matching sink or checker sits on the NoC output port.

Parameters:
- FLIT_WIDTH, 34, flit width in bits; must be >= 2*DEST_WIDTH+16.
- NODES, 16, node count; power of two, >= 2.
- NODE_ID, 0, this node's index, 0..NODES-1.
- PKT_LEN, 4, flits per packet including header; >= 1.
- DEST_WIDTH, $clog2(NODES), derived; do not override.
- LFSR_SEED, 16'hACE1, reset value of the destination LFSR; must be non-zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  start/continue generation; sampled only when not mid-packet.
- num_packets  in  16  packets to send; 0 = unlimited. Sampled on IDLE->HEADER.
- gap_cycles  in  8  idle cycles inserted after each packet's last flit.
- out_flit  out  FLIT_WIDTH  flit to NoC in_flit.
- out_last  out  1  last flit of packet.
- out_valid  out  1  flit valid.
- out_ready  in  1  NoC in_ready.
- done  out  1  programmed count reached.
- packets_sent  out  16  accepted-packet counter.

Behaviour:
- Reset: only one clock and one reset. Synchronous, active-high rst.
  - Outputs at reset: out_valid=0, out_last=0, out_flit=0, done=0, packets_sent=0.
  - State at reset: state=IDLE, lfsr=LFSR_SEED, seq=0, flit_idx=0, gap_cnt=0.
  - rst mid-packet aborts the packet immediately; no completing flits are sent.
- Transfer rule: a flit transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_flit and out_last hold stable.
  - out_valid never drops without a transfer.
- Header flit:
  - [FLIT_WIDTH-1 -: DEST_WIDTH] = dest.
  - next DEST_WIDTH bits = NODE_ID.
  - [15:0] = seq.
  - other bits = 0.
- Payload flit k (1..PKT_LEN-1): [31:16] = seq, [15:0] = k, upper bits 0.
- Destination: d = lfsr[DEST_WIDTH-1:0]. If d==NODE_ID, dest = (d+1) mod NODES (never self).
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). Advances exactly once per accepted header.
- FSM transitions:
  - IDLE: if enable && !done -> HEADER; out_valid=1 with header from the next cycle. Latch num_packets.
  - HEADER: on transfer:
    - PKT_LEN==1: out_last=1 on the header itself; packet completes.
    - otherwise -> PAYLOAD with flit_idx=1.
  - PAYLOAD: on each transfer flit_idx++. out_last=1 when flit_idx==PKT_LEN-1; packet completes on that transfer.
  - Packet completion:
    - packets_sent++ (wraps at 16'hFFFF->0); seq++ (wraps).
    - If num_packets!=0 and packets_sent+1==num_packets: done=1 -> DONE.
    - Else if gap_cycles!=0: gap_cnt=gap_cycles -> GAP.
    - Else -> IDLE; back-to-back header the following cycle if enable is still high.
  - GAP: out_valid=0. gap_cnt counts down; at 1 -> IDLE.
  - DONE: out_valid=0. Leaves only via rst.
- Deasserting enable mid-packet has no effect; the packet finishes and the block then waits in IDLE.
- Minimum bubble between packets: 1 cycle (IDLE visit).
- Throughput within a packet: 1 flit/cycle when out_ready=1.

Optional Feature:
- Macro: PERIPHERAL_NOC_TRAFFIC_GEN_STALL_STATS_EN.
- When defined:
  - Adds output port stall_cycles (32 bits), reset 0.
  - Increments every cycle with out_valid=1 && out_ready=0; saturates at 32'hFFFFFFFF.
  - Adds output port max_stall (16 bits): longest consecutive stall run, saturating.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Basic packet: NODE_ID=0, PKT_LEN=4, num_packets=1, gap=0, out_ready=1.
  - Expect 4 consecutive valid flits; header dest = lfsr-derived value (seed ACE1 -> d=1); seq=0.
  - Payload [15:0] = 1,2,3; out_last only on the 4th; then done=1, packets_sent=1.
- Backpressure: out_ready low for 5 cycles mid-packet.
  - Flit held stable, out_valid stays 1, no duplicate or skipped index.
  - With the macro: stall_cycles=5, max_stall=5.
- Gap and count: num_packets=3, gap_cycles=2.
  - Exactly 3 packets; 2 idle cycles plus 1 IDLE bubble between packets; seq 0,1,2; done after the third last flit.
- Self-avoid: NODES=2, NODE_ID=1, 20 packets.
  - Every header dest=0; LFSR sequence matches the reference model.
- Single-flit packets: PKT_LEN=1, num_packets=0, gap=0.
  - Header carries out_last=1 on every packet; never done; packets_sent wraps FFFF->0.
- Reset mid-packet: rst after flit 2 of 4.
  - Next cycle out_valid=0, packets_sent=0, seq=0; restart emits a header with seed-derived dest.

Source files
------------

// File: rtl/peripheral_noc_traffic_gen.sv
// peripheral_noc_traffic_gen: synthetic packet source for one NoC injection channel.
// Emits fixed-length packets to LFSR-chosen destinations that are never this node.
// A programmable gap follows each packet, and the block stops after a programmable
// packet count.
// Optional build macro PERIPHERAL_NOC_TRAFFIC_GEN_STALL_STATS_EN adds backpressure
// statistics outputs (stall_cycles, max_stall).
// Handshake: a flit transfers on a cycle where out_valid && out_ready. Once out_valid
// is raised, out_flit/out_last hold stable and out_valid stays high until that transfer.
module peripheral_noc_traffic_gen #(
    parameter int          FLIT_WIDTH = 34,
    parameter int          NODES      = 16,
    parameter int          NODE_ID    = 0,
    parameter int          PKT_LEN    = 4,
    parameter int          DEST_WIDTH = $clog2(NODES),
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [15:0]           num_packets,
    input  logic [7:0]            gap_cycles,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic [15:0]           packets_sent,
`ifdef PERIPHERAL_NOC_TRAFFIC_GEN_STALL_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [15:0]           max_stall,
`endif
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [DEST_WIDTH-1:0] L_NODE     = DEST_WIDTH'(NODE_ID);
    localparam logic [15:0]           L_LAST_IDX = 16'(PKT_LEN - 1);
    localparam logic [15:0]           L_MASK     = 16'hB400;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_lfsr;
    logic [15:0]           r_seq;
    logic [15:0]           r_flit_idx;
    logic [7:0]            r_gap_cnt;
    logic [15:0]           r_num;
    logic                  r_done;
    logic [15:0]           r_sent;
    logic                  w_complete;
    logic                  w_hit;
    logic [DEST_WIDTH-1:0] w_d;
    logic [DEST_WIDTH-1:0] w_dest;
    logic [15:0]           w_lfsr_next;
    logic [FLIT_WIDTH-1:0] w_hdr;
    logic [FLIT_WIDTH-1:0] w_pay;

    // Destination from the low LFSR bits, bumped by one when it would hit this node
    assign w_d         = r_lfsr[DEST_WIDTH-1:0];
    assign w_dest      = (w_d == L_NODE) ? w_d + DEST_WIDTH'(1) : w_d;
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? L_MASK : 16'h0000);
    assign w_hit       = (r_num != 16'd0) && ((r_sent + 16'd1) == r_num);

    assign done         = r_done;
    assign packets_sent = r_sent;
    assign dbg_state    = r_state;

    // Assemble header and payload flit words from the current packet state
    always_comb begin
        w_hdr = '0;
        w_hdr[FLIT_WIDTH-1 -: DEST_WIDTH]            = w_dest;
        w_hdr[FLIT_WIDTH-1-DEST_WIDTH -: DEST_WIDTH] = L_NODE;
        w_hdr[15:0]                                  = r_seq;
        w_pay = '0;
        w_pay[31:16] = r_seq;
        w_pay[15:0]  = r_flit_idx;
    end

    // Next-state and channel outputs; flit words depend only on registered state, so they hold under stall
    always_comb begin
        w_next     = r_state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_flit   = '0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !r_done) w_next = S_HEADER;
            end
            S_HEADER: begin
                out_valid = 1'b1;
                out_flit  = w_hdr;
                out_last  = (PKT_LEN == 1);
                if (out_ready) begin
                    if (PKT_LEN == 1) w_complete = 1'b1;
                    else              w_next     = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                out_valid = 1'b1;
                out_flit  = w_pay;
                out_last  = (r_flit_idx == L_LAST_IDX);
                if (out_ready && out_last) w_complete = 1'b1;
            end
            S_GAP: begin
                if (r_gap_cnt <= 8'd1) w_next = S_IDLE;
            end
            S_DONE: begin
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_complete) begin
            if (w_hit)                   w_next = S_DONE;
            else if (gap_cycles != 8'd0) w_next = S_GAP;
            else                         w_next = S_IDLE;
        end
    end

    // State register plus packet bookkeeping (LFSR, sequence, flit index, gap, counters)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lfsr     <= LFSR_SEED;
            r_seq      <= 16'd0;
            r_flit_idx <= 16'd0;
            r_gap_cnt  <= 8'd0;
            r_num      <= 16'd0;
            r_done     <= 1'b0;
            r_sent     <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_HEADER) r_num <= num_packets;
            if (r_state == S_HEADER && out_ready) begin
                r_lfsr     <= w_lfsr_next;
                r_flit_idx <= 16'd1;
            end
            if (r_state == S_PAYLOAD && out_ready) r_flit_idx <= r_flit_idx + 16'd1;
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
            if (w_complete) begin
                r_sent     <= r_sent + 16'd1;
                r_seq      <= r_seq + 16'd1;
                r_flit_idx <= 16'd0;
                if (w_hit)                   r_done    <= 1'b1;
                else if (gap_cycles != 8'd0) r_gap_cnt <= gap_cycles;
            end
        end
    end

`ifdef PERIPHERAL_NOC_TRAFFIC_GEN_STALL_STATS_EN
    logic        w_stall;
    logic [15:0] r_run;
    logic [15:0] w_run_inc;

    assign w_stall   = out_valid && !out_ready;
    assign w_run_inc = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;

    // Saturating total stall count and longest consecutive stall run
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            max_stall    <= 16'd0;
            r_run        <= 16'd0;
        end else if (w_stall) begin
            if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
            r_run <= w_run_inc;
            if (w_run_inc > max_stall) max_stall <= w_run_inc;
        end else begin
            r_run <= 16'd0;
        end
    end
`endif

endmodule
